// File: rtl/phase_bank_ctrl_if.sv
// Command / status bus between the host-side command receiver and the
// phase bank controller.
//
// Signals
//   cmd_valid    host -> ctrl   command word valid
//   cmd_ready    ctrl -> host   controller accepts a command this cycle
//   cmd_data     host -> ctrl   [31:24] opcode, [23:16] channel, [15:8] phase, [0] enable
//   txfifo_full  fifo -> ctrl   TX FIFO cannot take a byte
//   txfifo_wr    ctrl -> fifo   one-cycle write strobe
//   txfifo_data  ctrl -> fifo   status byte written with txfifo_wr
//
// The master modport is the host/FIFO side; the slave modport is the controller.
interface phase_bank_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        txfifo_full;
  logic        txfifo_wr;
  logic [7:0]  txfifo_data;

  modport master (
    output cmd_valid,
    output cmd_data,
    output txfifo_full,
    input  cmd_ready,
    input  txfifo_wr,
    input  txfifo_data
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    input  txfifo_full,
    output cmd_ready,
    output txfifo_wr,
    output txfifo_data
  );
endinterface

// File: rtl/phase_bank_ctrl.sv
// Double-buffered phase/enable bank controller.
//
// Host commands fill a shadow bank. COMMIT arms an atomic shadow -> active
// copy that is performed on the next PWM frame boundary (frame_tick), so the
// PWM channels never observe a partially updated bank. After every commit or
// rejected command a single status byte is pushed into the TX FIFO.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   bus         command/status interface (slave side)
//   frame_tick  one-cycle strobe at PWM counter wrap, synchronous to clk
//   phase_out   active phases, channel i at [i*CLK_CNT_W +: CLK_CNT_W]
//   en_out      active channel enables
//   busy        high whenever the controller is not idle
//   err_cnt     saturating count of rejected commands
module phase_bank_ctrl #(
  parameter int           NUM_CHANNELS = 128,
  parameter int           CLK_CNT_W    = 8,
  parameter logic [7:0]   ACK_BYTE     = 8'hA5,
  parameter logic [7:0]   ERR_BYTE     = 8'hEE
) (
  input  logic                              clk,
  input  logic                              rst_n,
  phase_bank_ctrl_if.slave                  bus,
  input  logic                              frame_tick,
  output logic [NUM_CHANNELS*CLK_CNT_W-1:0] phase_out,
  output logic [NUM_CHANNELS-1:0]           en_out,
  output logic                              busy,
  output logic [7:0]                        err_cnt
);

  localparam int         CH_IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [8:0] NUM_CH_9 = 9'(NUM_CHANNELS);

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_COMMIT = 8'h02;
  localparam logic [7:0] OP_CLEAR  = 8'h03;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t state;

  logic [NUM_CHANNELS*CLK_CNT_W-1:0] shadow_phase;
  logic [NUM_CHANNELS-1:0]           shadow_en;
  logic [7:0]                        status_byte;

  // Command field decode.
  logic [7:0]           cmd_op;
  logic [7:0]           cmd_ch;
  logic [CLK_CNT_W-1:0] cmd_phase;
  logic                 cmd_en;
  logic                 cmd_fire;
  logic                 ch_in_range;
  logic [CH_IDX_W-1:0]  ch_idx;

  assign cmd_op      = bus.cmd_data[31:24];
  assign cmd_ch      = bus.cmd_data[23:16];
  assign cmd_phase   = bus.cmd_data[8 +: CLK_CNT_W];
  assign cmd_en      = bus.cmd_data[0];
  assign cmd_fire    = bus.cmd_valid & bus.cmd_ready;
  assign ch_in_range = ({1'b0, cmd_ch} < NUM_CH_9);
  assign ch_idx      = cmd_ch[CH_IDX_W-1:0];

  // Controller FSM with both banks and all host-visible outputs registered.
  // cmd_ready and busy are written alongside every state transition so they
  // always equal the decode of the state register (ready = IDLE, busy = !IDLE).
  // txfifo_wr defaults low each cycle, giving an exactly one-cycle strobe that
  // coincides with the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.cmd_ready   <= 1'b1;
      busy            <= 1'b0;
      bus.txfifo_wr   <= 1'b0;
      bus.txfifo_data <= 8'h00;
      status_byte     <= 8'h00;
      err_cnt         <= 8'h00;
      shadow_phase    <= '0;
      shadow_en       <= '0;
      phase_out       <= '0;
      en_out          <= '0;
    end else begin
      bus.txfifo_wr <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_fire) begin
            // Any command that is not a valid WRITE, COMMIT or CLEAR falls
            // through to the reject path and is acknowledged with ERR_BYTE.
            if (cmd_op == OP_WRITE && ch_in_range) begin
              shadow_phase[ch_idx*CLK_CNT_W +: CLK_CNT_W] <= cmd_phase;
              shadow_en[ch_idx]                           <= cmd_en;
            end else if (cmd_op == OP_COMMIT) begin
              state         <= ARMED;
              bus.cmd_ready <= 1'b0;
              busy          <= 1'b1;
            end else if (cmd_op == OP_CLEAR) begin
              shadow_phase <= '0;
              shadow_en    <= '0;
            end else begin
              if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
              end
              status_byte   <= ERR_BYTE;
              state         <= SEND;
              bus.cmd_ready <= 1'b0;
              busy          <= 1'b1;
            end
          end
        end

        ARMED: begin
          // Only a tick seen while already in ARMED counts; a tick coinciding
          // with the COMMIT accept was sampled in IDLE and is ignored there.
          if (frame_tick) begin
            phase_out   <= shadow_phase;
            en_out      <= shadow_en;
            status_byte <= ACK_BYTE;
            state       <= SEND;
          end
        end

        SEND: begin
          // Hold the byte for as long as the FIFO is full; it is never dropped.
          if (!bus.txfifo_full) begin
            bus.txfifo_wr   <= 1'b1;
            bus.txfifo_data <= status_byte;
            state           <= IDLE;
            bus.cmd_ready   <= 1'b1;
            busy            <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_bank_ctrl.sv
// Directed testbench for phase_bank_ctrl: one linear stimulus sequence with
// hand-computed expectations, checked by immediate assertions.
module tb_phase_bank_ctrl;

  localparam int NCH = 128;
  localparam int PW  = 8;
  localparam int BW  = NCH * PW;

  logic          clk;
  logic          rst_n;
  logic          frame_tick;
  logic [BW-1:0] phase_out;
  logic [NCH-1:0] en_out;
  logic          busy;
  logic [7:0]    err_cnt;

  phase_bank_ctrl_if bus ();

  phase_bank_ctrl #(
    .NUM_CHANNELS (NCH),
    .CLK_CNT_W    (PW),
    .ACK_BYTE     (8'hA5),
    .ERR_BYTE     (8'hEE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .frame_tick (frame_tick),
    .phase_out  (phase_out),
    .en_out     (en_out),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int exp_wr   = 0;

  logic [BW-1:0]  exp_phase;
  logic [NCH-1:0] exp_en;

  // Count FIFO writes mid-cycle, away from the edge that updates the strobe.
  always @(negedge clk) begin
    if (rst_n && bus.txfifo_wr) wr_count <= wr_count + 1;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bank(input string tag);
    int bad_ch;
    n_checks++;
    assert (phase_out === exp_phase && en_out === exp_en) else begin
      n_fail++;
      bad_ch = 0;
      for (int i = NCH - 1; i >= 0; i--) begin
        if (phase_out[i*PW +: PW] !== exp_phase[i*PW +: PW] || en_out[i] !== exp_en[i]) bad_ch = i;
      end
      $error("[TB] FAIL %s ch%0d observed=%0h/%0b expected=%0h/%0b", tag, bad_ch,
             phase_out[bad_ch*PW +: PW], en_out[bad_ch], exp_phase[bad_ch*PW +: PW], exp_en[bad_ch]);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] op, input logic [7:0] ch, input logic [7:0] ph, input logic en);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = {op, ch, ph, 7'd0, en};
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 32'd0;
  endtask

  task automatic wait_ready(input string tag);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.cmd_ready) got = 1;
      else step();
    end
    check_output(tag, 128'(got), 128'd1);
  endtask

  task automatic wait_tx(input string tag, input logic [7:0] exp_byte);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (bus.txfifo_wr) got = 1;
    end
    check_output({tag, "_wr"}, 128'(got), 128'd1);
    check_output({tag, "_byte"}, 128'(bus.txfifo_data), 128'(exp_byte));
  endtask

  task automatic commit_and_tick();
    apply_stimulus(8'h02, 8'd0, 8'd0, 1'b0);
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    frame_tick       = 1'b0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_data     = 32'd0;
    bus.txfifo_full  = 1'b0;
    exp_phase        = '0;
    exp_en           = '0;

    // Reset values
    step();
    step();
    check_output("rst_ready", 128'(bus.cmd_ready), 128'd1);
    check_output("rst_busy", 128'(busy), 128'd0);
    check_output("rst_wr", 128'(bus.txfifo_wr), 128'd0);
    check_output("rst_data", 128'(bus.txfifo_data), 128'd0);
    check_output("rst_err", 128'(err_cnt), 128'd0);
    check_bank("rst_bank");
    rst_n = 1'b1;
    step();

    // 1: WRITE without COMMIT, ticks do nothing
    apply_stimulus(8'h01, 8'd5, 8'h40, 1'b1);
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
    check_bank("t1_bank");
    check_output("t1_wrcnt", 128'(wr_count), 128'd0);
    check_output("t1_ready", 128'(bus.cmd_ready), 128'd1);

    // 2: COMMIT, tick 10 cycles later
    apply_stimulus(8'h02, 8'd0, 8'd0, 1'b0);
    check_output("t2_ready_lo", 128'(bus.cmd_ready), 128'd0);
    check_output("t2_busy", 128'(busy), 128'd1);
    for (int i = 0; i < 9; i++) begin
      step();
      check_output("t2_armed_ready", 128'(bus.cmd_ready), 128'd0);
    end
    check_bank("t2_pre_tick");
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    exp_phase[5*PW +: PW] = 8'h40;
    exp_en[5]             = 1'b1;
    check_bank("t2_copy");
    check_output("t2_wr_lo", 128'(bus.txfifo_wr), 128'd0);
    check_output("t2_send_ready", 128'(bus.cmd_ready), 128'd0);
    step();
    check_output("t2_wr_hi", 128'(bus.txfifo_wr), 128'd1);
    check_output("t2_byte", 128'(bus.txfifo_data), 128'hA5);
    check_output("t2_ready_hi", 128'(bus.cmd_ready), 128'd1);
    check_output("t2_busy_lo", 128'(busy), 128'd0);
    step();
    check_output("t2_wr_once", 128'(bus.txfifo_wr), 128'd0);
    exp_wr = 1;
    check_output("t2_wrcnt", 128'(wr_count), 128'(exp_wr));

    // 3: tick in the COMMIT accept cycle is ignored
    apply_stimulus(8'h01, 8'd7, 8'h33, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = {8'h02, 24'd0};
    frame_tick    = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 32'd0;
    frame_tick    = 1'b0;
    check_output("t3_busy", 128'(busy), 128'd1);
    step();
    step();
    check_bank("t3_no_copy");
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    exp_phase[7*PW +: PW] = 8'h33;
    exp_en[7]             = 1'b1;
    check_bank("t3_copy");
    wait_tx("t3_ack", 8'hA5);
    exp_wr++;

    // 4: rejects leave shadow untouched; back-to-back commits still ACK
    apply_stimulus(8'h01, 8'd200, 8'h99, 1'b1);
    check_output("t4_err1", 128'(err_cnt), 128'd1);
    wait_tx("t4_err_byte", 8'hEE);
    exp_wr++;
    wait_ready("t4_ready1");
    apply_stimulus(8'h01, 8'd128, 8'h77, 1'b1);
    check_output("t4_err2", 128'(err_cnt), 128'd2);
    wait_tx("t4_err_byte2", 8'hEE);
    exp_wr++;
    wait_ready("t4_ready2");
    commit_and_tick();
    check_bank("t4_shadow_same");
    wait_tx("t4_ack1", 8'hA5);
    exp_wr++;
    commit_and_tick();
    check_bank("t4_recopy");
    wait_tx("t4_ack2", 8'hA5);
    exp_wr++;

    for (int i = 0; i < 300; i++) begin
      apply_stimulus(8'h7F, 8'd0, 8'd0, 1'b0);
      wait_ready("t4_bad_op_ready");
    end
    exp_wr += 300;
    check_output("t4_err_sat", 128'(err_cnt), 128'hFF);
    step();
    check_output("t4_wrcnt", 128'(wr_count), 128'(exp_wr));

    // CLEAR wipes shadow only; a commit then zeroes active
    apply_stimulus(8'h03, 8'd0, 8'd0, 1'b0);
    check_bank("clr_active_kept");
    commit_and_tick();
    exp_phase = '0;
    exp_en    = '0;
    check_bank("clr_commit");
    wait_tx("clr_ack", 8'hA5);
    exp_wr++;
    check_output("clr_err_kept", 128'(err_cnt), 128'hFF);

    // 5: FIFO full while sending
    apply_stimulus(8'h01, 8'd0, 8'hAB, 1'b1);
    apply_stimulus(8'h01, 8'd127, 8'hFF, 1'b0);
    bus.txfifo_full = 1'b1;
    commit_and_tick();
    exp_phase[0*PW +: PW]   = 8'hAB;
    exp_en[0]               = 1'b1;
    exp_phase[127*PW +: PW] = 8'hFF;
    check_bank("t5_copy");
    for (int i = 0; i < 20; i++) begin
      step();
      check_output("t5_full_wr", 128'(bus.txfifo_wr), 128'd0);
    end
    check_output("t5_full_busy", 128'(busy), 128'd1);
    check_output("t5_full_ready", 128'(bus.cmd_ready), 128'd0);
    bus.txfifo_full = 1'b0;
    wait_tx("t5_ack", 8'hA5);
    exp_wr++;
    step();
    step();
    check_output("t5_wrcnt", 128'(wr_count), 128'(exp_wr));

    // 6: reset while ARMED discards the commit
    apply_stimulus(8'h01, 8'd9, 8'h55, 1'b1);
    apply_stimulus(8'h02, 8'd0, 8'd0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    exp_phase = '0;
    exp_en    = '0;
    check_bank("t6_rst_bank");
    check_output("t6_rst_ready", 128'(bus.cmd_ready), 128'd1);
    check_output("t6_rst_busy", 128'(busy), 128'd0);
    check_output("t6_rst_err", 128'(err_cnt), 128'd0);
    check_output("t6_rst_data", 128'(bus.txfifo_data), 128'd0);
    step();
    rst_n = 1'b1;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    step();
    step();
    check_bank("t6_no_copy");
    check_output("t6_busy", 128'(busy), 128'd0);
    check_output("t6_wrcnt", 128'(wr_count), 128'(exp_wr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
